pll_lock_reset_seq: RTL

Reset sequencer for the fabric clock domain, directly downstream of the fabric CCC. It runs on the CCC's GL0 output and consumes the asynchronous PLL LOCK and the MSS-ready indication. It releases the fabric reset only after LOCK has been stable for a programmable time, then releases the RISC-V core reset after a further delay. It also handles PLL lock loss and debug-requested core-only resets, and keeps a sticky lock-loss record for software.

---
 rtl/pll_lock_reset_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_reset_seq.sv
// Fabric/core reset sequencer for the CCC GL0 domain: waits for a stable PLL lock,
// releases fabric then core reset, and handles lock loss and debug core resets.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_WAIT   | both resets held, waiting for synchronized LOCK and MSS_READY
// S_STABLE | both resets held, timing the LOCK/MSS_READY stability window
// S_FAB_UP | fabric released, core held for the core delay
// S_RUN    | both resets released
// S_SOFT   | fabric released, core pulsed low for a soft reset request
module pll_lock_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CORE_DELAY_CYCLES  = 16,
    parameter int SOFT_RESET_CYCLES  = 32,
    parameter int CNT_W              = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LOCK,
    input  logic       MSS_READY,
    input  logic       SOFT_RESET_REQ,
    input  logic       CLEAR_LOST,
    output logic       FABRIC_RESET_N,
    output logic       CORE_RESET_N,
    output logic       LOCK_LOST,
    output logic [7:0] LOCK_LOSS_COUNT
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_STABLE = 3'd1,
        S_FAB_UP = 3'd2,
        S_RUN    = 3'd3,
        S_SOFT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RESET_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;
    logic             rdy_meta;
    logic             rdy_s;
    logic             lock_loss;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            rdy_meta  <= 1'b0;
            rdy_s     <= 1'b0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
            rdy_meta  <= MSS_READY;
            rdy_s     <= rdy_meta;
        end
    end

    // Only lock loss tears down a released system; rdy_s is ignored past STABLE.
    assign lock_loss = !lock_s && (state == S_FAB_UP || state == S_RUN || state == S_SOFT);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state           <= S_WAIT;
            cnt             <= '0;
            FABRIC_RESET_N  <= 1'b0;
            CORE_RESET_N    <= 1'b0;
            LOCK_LOST       <= 1'b0;
            LOCK_LOSS_COUNT <= 8'd0;
        end else begin
            if (lock_loss) begin
                LOCK_LOST <= 1'b1;
                if (LOCK_LOSS_COUNT != 8'hFF) begin
                    LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + 8'd1;
                end
            end else if (CLEAR_LOST) begin
                LOCK_LOST <= 1'b0;
            end

            if (lock_loss) begin
                state          <= S_WAIT;
                cnt            <= '0;
                FABRIC_RESET_N <= 1'b0;
                CORE_RESET_N   <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (lock_s && rdy_s) begin
                            state <= S_STABLE;
                            cnt   <= '0;
                        end
                    end
                    S_STABLE: begin
                        if (!(lock_s && rdy_s)) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state          <= S_FAB_UP;
                            cnt            <= '0;
                            FABRIC_RESET_N <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_FAB_UP: begin
                        if (cnt == CORE_LAST) begin
                            state        <= S_RUN;
                            cnt          <= '0;
                            CORE_RESET_N <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (SOFT_RESET_REQ) begin
                            state        <= S_SOFT;
                            cnt          <= '0;
                            CORE_RESET_N <= 1'b0;
                        end
                    end
                    S_SOFT: begin
                        if (cnt == SOFT_LAST) begin
                            state        <= S_RUN;
                            cnt          <= '0;
                            CORE_RESET_N <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state          <= S_WAIT;
                        cnt            <= '0;
                        FABRIC_RESET_N <= 1'b0;
                        CORE_RESET_N   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
